// File: rtl/nios_system_cpu_1_oci_pkg.sv
// Shared constants, jdo field positions and state encoding for the OCI debug memory.
package nios_system_cpu_1_oci_pkg;

    localparam int unsigned RAM_W        = 32;
    localparam int unsigned RAM_BE_W     = RAM_W / 8;
    localparam int unsigned JDO_W        = 38;
    localparam int unsigned JDO_RD_BIT   = 35;
    localparam int unsigned JDO_CLR_BIT  = 37;
    localparam int unsigned JDO_DATA_LSB = 3;
    localparam int unsigned JDO_DATA_MSB = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        J_RD  = 2'd1,
        AV_RD = 2'd2
    } state_t;

    // Write-data field carried by an ocimem_b command.
    function automatic logic [RAM_W-1:0] jdo_data(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    endfunction

endpackage

// File: rtl/nios_system_cpu_1_oci_debug_mem_if.sv
// Avalon-MM slave bundle for the CPU-side port of the debug RAM.
interface nios_system_cpu_1_oci_debug_mem_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              debugaccess;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output debugaccess, avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  debugaccess, avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/nios_system_cpu_1_ociram_sp.sv
// Single-port debug RAM: per-byte write enable, registered read data, no reset on contents.
module nios_system_cpu_1_ociram_sp
    import nios_system_cpu_1_oci_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [RAM_W-1:0]    wdata,
    input  logic [RAM_BE_W-1:0] be,
    input  logic                we,
    input  logic                re,
    output logic [RAM_W-1:0]    q
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [RAM_W-1:0] mem [DEPTH];
    logic [RAM_W-1:0] q_q;

    // Byte-lane writes and one-cycle registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < RAM_BE_W; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) q_q <= mem[addr];
    end

    assign q = q_q;

endmodule

// File: rtl/nios_system_cpu_1_oci_debug_mem.sv
// JTAG debug memory command executor sharing a single-port RAM with an Avalon-MM slave.
// JTAG operations take priority over Avalon. Optional build macro OCIMEM_WPROT_EN:
// Avalon writes without debugaccess complete the handshake but leave the RAM untouched.
module nios_system_cpu_1_oci_debug_mem
    import nios_system_cpu_1_oci_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned JDO_ADDR_LSB = 26
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [JDO_W-1:0]                   jdo,
    input  logic                               take_action_ocimem_a,
    input  logic                               take_action_ocimem_b,
    input  logic                               take_no_action_ocimem_a,
    nios_system_cpu_1_oci_debug_mem_if.slave   avs,
    output logic [RAM_W-1:0]                   MonDReg,
    output logic                               mon_busy,
    output logic                               mon_overrun
);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
    logic [RAM_W-1:0]    mon_d_q, mon_d_d;
    logic                jrd_pend_q, jrd_pend_d;
    logic                jwr_pend_q, jwr_pend_d;
    logic                jinc_q, jinc_d;
    logic                overrun_q, overrun_d;
    logic [RAM_W-1:0]    readdata_q, readdata_d;

    logic [ADDR_W-1:0]   ram_addr;
    logic [RAM_W-1:0]    ram_wdata;
    logic [RAM_BE_W-1:0] ram_be;
    logic                ram_we;
    logic                ram_re;
    logic [RAM_W-1:0]    ram_q;
    logic                busy_c;
    logic                pulse_c;
    logic                wr_allow_c;
    logic                waitrequest_c;
    logic                unused_debugaccess;

`ifdef OCIMEM_WPROT_EN
    assign wr_allow_c = avs.debugaccess;
`else
    assign wr_allow_c = 1'b1;
`endif
    assign unused_debugaccess = avs.debugaccess;

    assign busy_c  = jrd_pend_q | jwr_pend_q | (state_q == J_RD);
    assign pulse_c = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Arbitration FSM, RAM port control and JTAG command decode.
    always_comb begin
        state_d       = state_q;
        mon_a_d       = mon_a_q;
        mon_d_d       = mon_d_q;
        jrd_pend_d    = jrd_pend_q;
        jwr_pend_d    = jwr_pend_q;
        jinc_d        = jinc_q;
        overrun_d     = overrun_q;
        readdata_d    = readdata_q;
        ram_addr      = mon_a_q;
        ram_wdata     = mon_d_q;
        ram_be        = '1;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        waitrequest_c = 1'b1;

        case (state_q)
            IDLE: begin
                if (jwr_pend_q) begin
                    ram_we     = 1'b1;
                    mon_a_d    = mon_a_q + ADDR_W'(1);
                    jwr_pend_d = 1'b0;
                end else if (jrd_pend_q) begin
                    ram_re  = 1'b1;
                    state_d = J_RD;
                end else if (avs.avs_write) begin
                    ram_addr      = avs.avs_address;
                    ram_wdata     = avs.avs_writedata;
                    ram_be        = avs.avs_byteenable;
                    ram_we        = wr_allow_c;
                    waitrequest_c = 1'b0;
                end else if (avs.avs_read) begin
                    ram_addr = avs.avs_address;
                    ram_re   = 1'b1;
                    state_d  = AV_RD;
                end
            end
            J_RD: begin
                mon_d_d    = ram_q;
                if (jinc_q) mon_a_d = mon_a_q + ADDR_W'(1);
                jrd_pend_d = 1'b0;
                jinc_d     = 1'b0;
                state_d    = IDLE;
            end
            AV_RD: begin
                readdata_d    = ram_q;
                waitrequest_c = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Host commands are only accepted while nothing JTAG-side is outstanding.
        if (pulse_c && busy_c) begin
            overrun_d = 1'b1;
        end else if (take_action_ocimem_a) begin
            mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_RD_BIT]) begin
                jrd_pend_d = 1'b1;
                jinc_d     = 1'b0;
            end
            if (jdo[JDO_CLR_BIT]) overrun_d = 1'b0;
        end else if (take_action_ocimem_b) begin
            mon_d_d    = jdo_data(jdo);
            jwr_pend_d = 1'b1;
        end else if (take_no_action_ocimem_a) begin
            jrd_pend_d = 1'b1;
            jinc_d     = 1'b1;
        end

        // Keep the RAM quiet and the bus stalled while reset is held.
        if (reset) begin
            ram_we        = 1'b0;
            ram_re        = 1'b0;
            waitrequest_c = 1'b1;
        end
    end

    // State and register file update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mon_a_q    <= '0;
            mon_d_q    <= '0;
            jrd_pend_q <= 1'b0;
            jwr_pend_q <= 1'b0;
            jinc_q     <= 1'b0;
            overrun_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mon_a_q    <= mon_a_d;
            mon_d_q    <= mon_d_d;
            jrd_pend_q <= jrd_pend_d;
            jwr_pend_q <= jwr_pend_d;
            jinc_q     <= jinc_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
        end
    end

    nios_system_cpu_1_ociram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .we    (ram_we),
        .re    (ram_re),
        .q     (ram_q)
    );

    assign avs.avs_readdata    = readdata_q;
    assign avs.avs_waitrequest = waitrequest_c;
    assign MonDReg             = mon_d_q;
    assign mon_busy            = busy_c;
    assign mon_overrun         = overrun_q;

endmodule

// File: tb/tb_nios_system_cpu_1_oci_debug_mem.sv
// Directed self-checking bench for the OCI debug memory (JTAG commands, Avalon port, arbitration).
module tb_nios_system_cpu_1_oci_debug_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_b, take_n;
    logic [31:0] mon_d;
    logic        mon_busy, mon_overrun;
    int          n_cmp = 0;
    int          n_err = 0;

    nios_system_cpu_1_oci_debug_mem_if #(.ADDR_W(8)) avs_if ();

    nios_system_cpu_1_oci_debug_mem #(
        .ADDR_W       (8),
        .JDO_ADDR_LSB (26)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_n),
        .avs                     (avs_if),
        .MonDReg                 (mon_d),
        .mon_busy                (mon_busy),
        .mon_overrun             (mon_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] addr, input logic rd, input logic clr);
        jdo = '0;
        jdo[33:26] = addr;
        jdo[35] = rd;
        jdo[37] = clr;
        take_a = 1'b1;
        step();
        take_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        take_b = 1'b1;
        step();
        take_b = 1'b0;
    endtask

    task automatic pulse_n();
        take_n = 1'b1;
        step();
        take_n = 1'b0;
    endtask

    task automatic av_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic da);
        avs_if.avs_address    = addr;
        avs_if.avs_writedata  = data;
        avs_if.avs_byteenable = be;
        avs_if.debugaccess    = da;
        avs_if.avs_write      = 1'b1;
        #1;
        chk("av_wr_wait", 32'(avs_if.avs_waitrequest), 32'd0);
        step();
        avs_if.avs_write = 1'b0;
    endtask

    task automatic av_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        int n;
        n = 0;
        avs_if.avs_address = addr;
        avs_if.avs_read    = 1'b1;
        #1;
        while (avs_if.avs_waitrequest && n < 8) begin
            step();
            n++;
        end
        chk({tag, "_accept"}, 32'(avs_if.avs_waitrequest), 32'd0);
        avs_if.avs_read = 1'b0;
        step();
        chk(tag, avs_if.avs_readdata, exp);
    endtask

    initial begin
        reset  = 1'b1;
        jdo    = '0;
        take_a = 1'b0;
        take_b = 1'b0;
        take_n = 1'b0;
        avs_if.debugaccess    = 1'b0;
        avs_if.avs_address    = '0;
        avs_if.avs_read       = 1'b0;
        avs_if.avs_write      = 1'b1;
        avs_if.avs_writedata  = '0;
        avs_if.avs_byteenable = '0;
        step();
        step();

        // Reset values (an Avalon write held during reset must still see a stall).
        chk("rst_wait", 32'(avs_if.avs_waitrequest), 32'd1);
        chk("rst_rdata", avs_if.avs_readdata, 32'd0);
        chk("rst_mond", mon_d, 32'd0);
        chk("rst_busy", 32'(mon_busy), 32'd0);
        chk("rst_ovr", 32'(mon_overrun), 32'd0);
        avs_if.avs_write = 1'b0;
        reset = 1'b0;
        step();

        // Seed RAM[0x11] over Avalon.
        av_write(8'h11, 32'h1234_5678, 4'hF, 1'b1);

        // JTAG write DEADBEEF at 0x10.
        pulse_a(8'h10, 1'b0, 1'b0);
        chk("a_norm_busy", 32'(mon_busy), 32'd0);
        pulse_b(32'hDEAD_BEEF);
        chk("b_mond", mon_d, 32'hDEAD_BEEF);
        chk("b_busy", 32'(mon_busy), 32'd1);
        step();
        chk("b_busy_done", 32'(mon_busy), 32'd0);

        // JTAG read at 0x11: two-cycle latency into MonDReg.
        pulse_a(8'h11, 1'b1, 1'b0);
        chk("rd11_busy", 32'(mon_busy), 32'd1);
        chk("rd11_early", mon_d, 32'hDEAD_BEEF);
        step();
        chk("rd11_jrd_busy", 32'(mon_busy), 32'd1);
        step();
        chk("rd11_mond", mon_d, 32'h1234_5678);
        chk("rd11_idle", 32'(mon_busy), 32'd0);

        // Read at 0x10 without increment, then two auto-increment reads.
        pulse_a(8'h10, 1'b1, 1'b0);
        step();
        step();
        chk("rd10_mond", mon_d, 32'hDEAD_BEEF);
        pulse_n();
        step();
        step();
        chk("inc0_mond", mon_d, 32'hDEAD_BEEF);
        pulse_n();
        step();
        step();
        chk("inc1_mond", mon_d, 32'h1234_5678);

        // MonAReg should now be 0x12: write there and read back over Avalon.
        pulse_b(32'hCAFE_F00D);
        step();
        av_read("rd12", 8'h12, 32'hCAFE_F00D);

        // Address wrap 0xFF -> 0x00.
        pulse_a(8'hFF, 1'b0, 1'b0);
        pulse_b(32'h0000_0001);
        step();
        pulse_b(32'h0000_0077);
        step();
        av_read("rdff", 8'hFF, 32'h0000_0001);
        av_read("rd00", 8'h00, 32'h0000_0077);

        // Avalon read collides with a pending JTAG read: JTAG first.
        pulse_a(8'h10, 1'b1, 1'b0);
        avs_if.avs_address = 8'h10;
        avs_if.avs_read    = 1'b1;
        #1;
        chk("arb_wait_pend", 32'(avs_if.avs_waitrequest), 32'd1);
        step();
        chk("arb_wait_jrd", 32'(avs_if.avs_waitrequest), 32'd1);
        step();
        chk("arb_mond", mon_d, 32'hDEAD_BEEF);
        chk("arb_wait_issue", 32'(avs_if.avs_waitrequest), 32'd1);
        step();
        chk("arb_accept", 32'(avs_if.avs_waitrequest), 32'd0);
        avs_if.avs_read = 1'b0;
        step();
        chk("arb_rdata", avs_if.avs_readdata, 32'hDEAD_BEEF);

        // Overrun: second pulse while busy is dropped.
        pulse_a(8'h11, 1'b1, 1'b0);
        pulse_a(8'h10, 1'b1, 1'b0);
        chk("ovr_set", 32'(mon_overrun), 32'd1);
        step();
        chk("ovr_mond", mon_d, 32'h1234_5678);
        chk("ovr_busy", 32'(mon_busy), 32'd0);
        pulse_n();
        step();
        step();
        chk("ovr_addr_kept", mon_d, 32'h1234_5678);
        chk("ovr_sticky", 32'(mon_overrun), 32'd1);
        pulse_a(8'h10, 1'b0, 1'b1);
        chk("ovr_clear", 32'(mon_overrun), 32'd0);

        // Avalon byte enables.
        av_write(8'h21, 32'hFFFF_FFFF, 4'hF, 1'b1);
        av_write(8'h21, 32'h1122_3344, 4'b0101, 1'b1);
        av_read("be21", 8'h21, 32'hFF22_FF44);

        // Write protection on debugaccess.
        av_write(8'h20, 32'h0000_0000, 4'hF, 1'b1);
        av_write(8'h20, 32'hA5A5_A5A5, 4'hF, 1'b0);
`ifdef OCIMEM_WPROT_EN
        av_read("wp_blocked", 8'h20, 32'h0000_0000);
`else
        av_read("wp_open", 8'h20, 32'hA5A5_A5A5);
`endif
        av_write(8'h20, 32'hA5A5_A5A5, 4'hF, 1'b1);
        av_read("wp_debug", 8'h20, 32'hA5A5_A5A5);

        // Reset in the middle of a JTAG read.
        pulse_a(8'h11, 1'b1, 1'b0);
        step();
        reset = 1'b1;
        avs_if.avs_write = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(mon_busy), 32'd0);
        chk("mid_rst_mond", mon_d, 32'd0);
        chk("mid_rst_wait", 32'(avs_if.avs_waitrequest), 32'd1);
        step();
        reset = 1'b0;
        avs_if.avs_write = 1'b0;
        step();
        chk("post_rst_mond", mon_d, 32'd0);
        pulse_n();
        step();
        step();
        chk("post_rst_rd0", mon_d, 32'h0000_0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nios_system_cpu_1_oci_debug_mem.md
Name: nios_system_cpu_1_oci_debug_mem

Overview:
- Downstream consumer of the JTAG debug module's sysclk-domain outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Executes host JTAG memory commands against a single-port on-chip debug RAM.
- Returns read data on MonDReg, which the JTAG tck stage shifts back out.
- The same RAM is exposed to the CPU through an Avalon-MM slave port; pending JTAG operations take priority over Avalon.

Parameters:
- ADDR_W, 8, debug RAM word-address width (RAM depth is 2**ADDR_W words of 32 bits).
- JDO_ADDR_LSB, 26, bit position of the address field inside jdo.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  JTAG data captured in the sysclk domain.
- take_action_ocimem_a  in  1  one-cycle pulse: load address, optional read.
- take_action_ocimem_b  in  1  one-cycle pulse: write data, then auto-increment.
- take_no_action_ocimem_a  in  1  one-cycle pulse: read at current address, then auto-increment.
- debugaccess  in  1  Avalon access originates from debug code.
- avs_address  in  ADDR_W  Avalon word address.
- avs_read  in  1  Avalon read.
- avs_write  in  1  Avalon write.
- avs_writedata  in  32  Avalon write data.
- avs_byteenable  in  4  Avalon byte enables.
- avs_readdata  out  32  Avalon read data.
- avs_waitrequest  out  1  Avalon stall.
- MonDReg  out  32  monitor data register returned to JTAG.
- mon_busy  out  1  a JTAG operation is pending or in flight.
- mon_overrun  out  1  sticky: a JTAG action arrived while busy.

Behaviour:
- Reset (asynchronous) clears the following; RAM contents are not reset:
  - MonAReg = 0, MonDReg = 0, state = IDLE, pending flags = 0;
  - avs_waitrequest = 1, avs_readdata = 0, mon_busy = 0, mon_overrun = 0.
- JTAG command decode, on each pulse (mutually exclusive by construction):
  - ocimem_a: MonAReg <= jdo[JDO_ADDR_LSB+ADDR_W-1:JDO_ADDR_LSB]; if jdo[35] = 1, set jrd_pend (read at the new address, no increment).
  - ocimem_b: MonDReg <= jdo[34:3]; set jwr_pend.
  - no_action_ocimem_a: set jrd_pend with auto-increment (jinc = 1).
- Overrun: any pulse while mon_busy = 1 is dropped entirely (no register update) and sets mon_overrun. mon_overrun clears only on reset or on an ocimem_a pulse with jdo[37] = 1 received while idle.
- mon_busy = jrd_pend | jwr_pend | (state == J_RD).
- RAM: single port, 1-cycle registered read latency, 32 bits wide, per-byte write enable.
- State machine (IDLE, J_RD, AV_RD):
  - IDLE, jwr_pend: write MonDReg to RAM[MonAReg] with all bytes enabled; MonAReg++ (wraps 2**ADDR_W-1 -> 0); clear jwr_pend; stay IDLE.
  - IDLE, jrd_pend: issue read at MonAReg; go to J_RD.
  - J_RD: MonDReg <= RAM q; if jinc, MonAReg++ (with wrap); clear jrd_pend; go to IDLE.
  - IDLE, no JTAG pending, avs_write: write with avs_byteenable; avs_waitrequest = 0 this cycle (zero-wait write).
  - IDLE, no JTAG pending, avs_read: issue read; go to AV_RD.
  - AV_RD: avs_readdata <= q; avs_waitrequest = 0; go to IDLE. Read latency is 2 clk cycles from request to acceptance.
- Arbitration:
  - avs_waitrequest = 1 in every other case, including J_RD and any cycle where a JTAG op is pending.
  - A JTAG pending flag and an Avalon request in the same IDLE cycle: JTAG wins and Avalon stalls.
  - A JTAG pulse arriving during AV_RD is latched and serviced on the next IDLE cycle.
- Reset asserted mid-operation: the in-flight op is abandoned; no partial MonAReg increment; avs_waitrequest returns to 1.

Optional Feature:
- Macro: OCIMEM_WPROT_EN.
- Defined: an Avalon write with debugaccess = 0 completes the handshake (waitrequest = 0 for one cycle) but does not modify the RAM.
- Undefined: debugaccess is ignored and every Avalon write updates the RAM.
- JTAG writes are never blocked in either build.

Decomposition:
- Shared package nios_system_cpu_1_oci_pkg holds:
  - jdo field constants: JDO_RD_BIT = 35, JDO_CLR_BIT = 37, data field [34:3];
  - the state enum (IDLE, J_RD, AV_RD);
  - the RAM width constant (32).
- One sub-module, nios_system_cpu_1_ociram_sp: single-port RAM with byte enables and registered q.

Test Plan:
- ocimem_a, jdo[33:26] = 8'h10, jdo[35] = 0; then ocimem_b with data 32'hDEADBEEF -> RAM[0x10] = DEADBEEF, MonAReg = 0x11, mon_busy low within 1 cycle.
- ocimem_a, addr = 0x10, jdo[35] = 1 -> MonDReg = DEADBEEF 2 cycles after the pulse, MonAReg stays 0x10. Then no_action_ocimem_a x2 -> MonDReg holds RAM[0x10] then RAM[0x11]; MonAReg ends at 0x12.
- ocimem_a, addr = 0xFF; then ocimem_b with 32'h1 -> RAM[0xFF] = 1, MonAReg wraps to 0x00.
- avs_read of 0x10 in the same cycle jrd_pend is set -> waitrequest held until the JTAG read completes, then avs_readdata = DEADBEEF with waitrequest = 0 exactly 2 cycles later.
- Second pulse one cycle after a read pulse -> mon_overrun = 1, MonAReg unchanged; ocimem_a with jdo[37] = 1 while idle -> mon_overrun = 0.
- With OCIMEM_WPROT_EN defined: avs_write 0x20 = 32'hA5A5A5A5 with debugaccess = 0 -> RAM[0x20] unchanged; same write with debugaccess = 1 -> RAM[0x20] = A5A5A5A5.
